vdp_reg_write_arbiter: RTL and testbench

VDP_REG_WRITE_ARBITER -- requirements
Module: vdp_reg_write_arbiter

---
 rtl/vdp_pkg.sv | 30 +++
 rtl/vdp_reg_write_arbiter_if.sv | 54 +++++
 rtl/vdp_reg_write_fifo.sv | 77 +++++++
 rtl/vdp_reg_write_arbiter.sv | 152 +++++++++++++++
 tb/tb_vdp_reg_write_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// -----------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the VDP register-write path: bus widths, the
// reg_write_source encoding, the packed copper write entry and the grant
// encoding used by the arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package vdp_pkg;

   localparam int VDP_REG_ADDR_W = 6;
   localparam int VDP_REG_DATA_W = 16;

   // reg_write_source encoding
   localparam logic SRC_HOST   = 1'b0;
   localparam logic SRC_COPPER = 1'b1;

   // One queued copper write: address in the upper bits, data in the lower.
   typedef struct packed {
      logic [VDP_REG_ADDR_W-1:0] addr;
      logic [VDP_REG_DATA_W-1:0] data;
   } vdp_reg_write_t;

   // Which requester owns the register-file port in the current cycle.
   typedef enum logic [1:0] {
      GRANT_NONE   = 2'd0,
      GRANT_HOST   = 2'd1,
      GRANT_COPPER = 2'd2
   } grant_e;

endpackage

// File: rtl/vdp_reg_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// vdp_reg_write_arbiter_if
// Bundles the copper request, host request, register-file write and copper
// occupancy signals of the register-write arbiter.
//   master : the requesters / register-file side (drives requests, observes
//            readies, write strobe and level)
//   slave  : the arbiter itself
// Parameter FIFO_DEPTH sizes cop_fifo_level ($clog2(FIFO_DEPTH)+1 bits) and
// must match the arbiter's FIFO_DEPTH.
// -----------------------------------------------------------------------------
interface vdp_reg_write_arbiter_if #(
   parameter int FIFO_DEPTH = 4
);
   import vdp_pkg::*;

   localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   // copper request channel
   logic [VDP_REG_ADDR_W-1:0] cop_write_address;
   logic [VDP_REG_DATA_W-1:0] cop_write_data;
   logic                      cop_write_en;
   logic                      cop_write_ready;
   // host (CPU) request channel
   logic [VDP_REG_ADDR_W-1:0] host_write_address;
   logic [VDP_REG_DATA_W-1:0] host_write_data;
   logic                      host_write_en;
   logic                      host_write_ready;
   // register-file write port
   logic [VDP_REG_ADDR_W-1:0] reg_write_address;
   logic [VDP_REG_DATA_W-1:0] reg_write_data;
   logic                      reg_write_en;
   logic                      reg_write_source;
   // copper queue occupancy
   logic [LEVEL_W-1:0]        cop_fifo_level;

   modport master (
      output cop_write_address, cop_write_data, cop_write_en,
      input  cop_write_ready,
      output host_write_address, host_write_data, host_write_en,
      input  host_write_ready,
      input  reg_write_address, reg_write_data, reg_write_en, reg_write_source,
      input  cop_fifo_level
   );

   modport slave (
      input  cop_write_address, cop_write_data, cop_write_en,
      output cop_write_ready,
      input  host_write_address, host_write_data, host_write_en,
      output host_write_ready,
      output reg_write_address, reg_write_data, reg_write_en, reg_write_source,
      output cop_fifo_level
   );

endinterface

// File: rtl/vdp_reg_write_fifo.sv
// -----------------------------------------------------------------------------
// vdp_reg_write_fifo
// Small synchronous FIFO holding queued copper register writes.
// The head entry is read combinationally so the arbiter can pop and register
// it in the same cycle.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_push, i_push_data write an entry (ignored while full)
//   i_pop, o_pop_data   o_pop_data is the head; i_pop removes it (ignored
//                       while empty)
//   o_full, o_empty     occupancy flags
//   o_level             number of stored entries (0..DEPTH)
// DEPTH must be a power of two >= 2 so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module vdp_reg_write_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 22
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_pop_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_level == FULL_LEVEL);
   assign o_empty    = (r_level == '0);
   assign o_level    = r_level;
   assign o_pop_data = r_mem[r_rd_ptr];

   // A push is refused while full even if a pop happens in the same cycle.
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // Storage is not reset; stale entries are unreachable once the pointers
   // and level are cleared.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
            2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/vdp_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// vdp_reg_write_arbiter
// Merges copper and host (CPU) register writes onto a single register-file
// write port, one write per cycle. Copper writes are queued and normally win;
// a host that keeps waiting is guaranteed a slot after HOST_STARVE_LIMIT
// consecutive copper grants.
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    vdp_reg_write_arbiter_if.slave: copper request/ready, host
//          request/ready, registered register-file write, copper level
// Build option:
//   VDP_COPPER_WRITE_FIFO_EN defined   : copper queue is a FIFO_DEPTH-entry
//                                        vdp_reg_write_fifo
//   VDP_COPPER_WRITE_FIFO_EN undefined : copper queue is one holding register
// -----------------------------------------------------------------------------
module vdp_reg_write_arbiter
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH        = 4,
   parameter int HOST_STARVE_LIMIT = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   vdp_reg_write_arbiter_if.slave  bus
);

   localparam int LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int STREAK_W = $clog2(HOST_STARVE_LIMIT + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(HOST_STARVE_LIMIT);

   // copper queue
   vdp_reg_write_t      w_cop_in;
   vdp_reg_write_t      w_cop_head;
   logic                w_cop_full;
   logic                w_cop_empty;
   logic                w_cop_push;
   logic                w_cop_pop;
   logic [LEVEL_W-1:0]  w_cop_level;

   // arbitration
   grant_e              w_grant;
   logic [STREAK_W-1:0] r_streak;
   logic [STREAK_W-1:0] w_streak_next;

   // registered register-file write
   logic                      r_reg_en;
   logic                      r_reg_src;
   logic [VDP_REG_ADDR_W-1:0] r_reg_addr;
   logic [VDP_REG_DATA_W-1:0] r_reg_data;

   assign w_cop_in        = {bus.cop_write_address, bus.cop_write_data};
   assign bus.cop_write_ready = !reset && !w_cop_full;
   assign w_cop_push      = bus.cop_write_en && bus.cop_write_ready;
   assign w_cop_pop       = (w_grant == GRANT_COPPER);
   assign bus.cop_fifo_level = w_cop_level;

`ifdef VDP_COPPER_WRITE_FIFO_EN
   vdp_reg_write_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(vdp_reg_write_t))
   ) u_cop_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_cop_push),
      .i_push_data (w_cop_in),
      .i_pop       (w_cop_pop),
      .o_pop_data  (w_cop_head),
      .o_full      (w_cop_full),
      .o_empty     (w_cop_empty),
      .o_level     (w_cop_level)
   );
`else
   // Single holding register: ready only while empty, so push and pop can
   // never coincide.
   logic           r_hold_valid;
   vdp_reg_write_t r_hold;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hold_valid <= 1'b0;
         r_hold       <= '0;
      end else begin
         if (w_cop_pop) begin
            r_hold_valid <= 1'b0;
         end
         if (w_cop_push) begin
            r_hold_valid <= 1'b1;
            r_hold       <= w_cop_in;
         end
      end
   end

   assign w_cop_full  = r_hold_valid;
   assign w_cop_empty = !r_hold_valid;
   assign w_cop_head  = r_hold;
   assign w_cop_level = {{(LEVEL_W-1){1'b0}}, r_hold_valid};
`endif

   // Copper wins unless the host has already been passed over
   // HOST_STARVE_LIMIT times in a row.
   always_comb begin
      w_grant = GRANT_NONE;
      if (!reset) begin
         if (!w_cop_empty && ((r_streak < STREAK_MAX) || !bus.host_write_en)) begin
            w_grant = GRANT_COPPER;
         end else if (bus.host_write_en) begin
            w_grant = GRANT_HOST;
         end
      end
   end

   assign bus.host_write_ready = (w_grant == GRANT_HOST);

   // Streak only counts copper grants that made a waiting host wait longer.
   always_comb begin
      w_streak_next = r_streak;
      if (!bus.host_write_en || (w_grant == GRANT_HOST)) begin
         w_streak_next = '0;
      end else if ((w_grant == GRANT_COPPER) && (r_streak != STREAK_MAX)) begin
         w_streak_next = r_streak + STREAK_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_streak   <= '0;
         r_reg_en   <= 1'b0;
         r_reg_src  <= SRC_HOST;
         r_reg_addr <= '0;
         r_reg_data <= '0;
      end else begin
         r_streak <= w_streak_next;
         r_reg_en <= (w_grant != GRANT_NONE);
         if (w_grant == GRANT_COPPER) begin
            r_reg_src  <= SRC_COPPER;
            r_reg_addr <= w_cop_head.addr;
            r_reg_data <= w_cop_head.data;
         end else if (w_grant == GRANT_HOST) begin
            r_reg_src  <= SRC_HOST;
            r_reg_addr <= bus.host_write_address;
            r_reg_data <= bus.host_write_data;
         end
      end
   end

   assign bus.reg_write_en      = r_reg_en;
   assign bus.reg_write_source  = r_reg_src;
   assign bus.reg_write_address = r_reg_addr;
   assign bus.reg_write_data    = r_reg_data;

endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdp_reg_write_arbiter
// Directed bench for vdp_reg_write_arbiter. Expected values are hand-derived
// for both builds (VDP_COPPER_WRITE_FIFO_EN defined or not).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vdp_reg_write_arbiter;
   import vdp_pkg::*;

   localparam int FIFO_DEPTH = 4;
`ifdef VDP_COPPER_WRITE_FIFO_EN
   localparam int CAP          = 4;  // copper entries before ready drops
   localparam int LVL_AT_RST   = 3;  // level in cycle 21 of the starvation run
   localparam int RDY_LOW_021  = 0;  // 6-write stream never fills the FIFO
`else
   localparam int CAP          = 1;
   localparam int LVL_AT_RST   = 1;
   localparam int RDY_LOW_021  = 1;  // holding register blocks every other cycle
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   vdp_reg_write_arbiter_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

   vdp_reg_write_arbiter #(
      .FIFO_DEPTH        (FIFO_DEPTH),
      .HOST_STARVE_LIMIT (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int saw_ready_low;
   logic [22:0] q[$];      // observed strobes {src, addr, data}
   logic [22:0] exp_q[$];  // expected strobes

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [5:0] cop_addr(input int i);
      return 6'((i * 3 + 1) % 64);
   endfunction
   function automatic logic [15:0] cop_data(input int i);
      return 16'(32'hC000 + i);
   endfunction
   function automatic logic [5:0] host_addr(input int j);
      return 6'(32'h20 + j);
   endfunction
   function automatic logic [15:0] host_data(input int j);
      return 16'(32'hA000 + j);
   endfunction
   function automatic logic [22:0] cop_ent(input int i);
      return {SRC_COPPER, cop_addr(i), cop_data(i)};
   endfunction
   function automatic logic [22:0] host_ent(input int j);
      return {SRC_HOST, host_addr(j), host_data(j)};
   endfunction

   // One line per register-file write.
   always @(negedge clk) begin
      if (!reset && bus.reg_write_en) begin
         q.push_back({bus.reg_write_source, bus.reg_write_address, bus.reg_write_data});
         $display("strobe src=%0d addr=0x%02h data=0x%04h",
                  bus.reg_write_source, bus.reg_write_address, bus.reg_write_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Streams n_cop copper writes and n_host host writes (host requests from
   // cycle host_from on). Returns early in cycle abort_cycle with inputs held.
   task automatic traffic(input int n_cop, input int n_host, input int host_from,
                          input int abort_cycle);
      int ci = 0;
      int hi = 0;
      int cyc = 0;
      saw_ready_low = 0;
      while ((ci < n_cop || hi < n_host) && cyc < 400) begin
         tick();
         bus.cop_write_en       = (ci < n_cop);
         bus.cop_write_address  = cop_addr(ci);
         bus.cop_write_data     = cop_data(ci);
         bus.host_write_en      = (hi < n_host) && (cyc >= host_from);
         bus.host_write_address = host_addr(hi);
         bus.host_write_data    = host_data(hi);
         @(negedge clk);
         check("ready_vs_level", bus.cop_write_ready, 32'(int'(bus.cop_fifo_level) < CAP));
         if (!bus.cop_write_ready) saw_ready_low = 1;
         if (cyc == abort_cycle) return;
         if (bus.cop_write_en && bus.cop_write_ready) ci++;
         if (bus.host_write_en && bus.host_write_ready) hi++;
         cyc++;
      end
      check("traffic_done", 32'(ci == n_cop && hi == n_host), 32'd1);
      tick();
      bus.cop_write_en  = 1'b0;
      bus.host_write_en = 1'b0;
   endtask

   task automatic drain_and_compare(input string tag);
      int guard = 0;
      while (q.size() < exp_q.size() && guard < 60) begin
         @(posedge clk);
         guard++;
      end
      repeat (4) @(posedge clk);
      @(negedge clk);
      check({tag, "_count"}, q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < q.size(); i++) begin
         check($sformatf("%s_%0d", tag, i), q[i], exp_q[i]);
      end
   endtask

   // Single copper write into an empty queue, host idle: strobe two cycles on.
   task automatic cop_single(input string tag, input logic [5:0] a, input logic [15:0] d);
      tick();
      bus.cop_write_en      = 1'b1;
      bus.cop_write_address = a;
      bus.cop_write_data    = d;
      #1;
      check({tag, "_ready"}, bus.cop_write_ready, 32'd1);
      tick();                          // accepted at this edge
      bus.cop_write_en = 1'b0;
      #1;
      check({tag, "_level1"}, bus.cop_fifo_level, 32'd1);
      check({tag, "_no_early"}, bus.reg_write_en, 32'd0);
      tick();
      check({tag, "_en"}, bus.reg_write_en, 32'd1);
      check({tag, "_addr"}, bus.reg_write_address, a);
      check({tag, "_data"}, bus.reg_write_data, d);
      check({tag, "_src"}, bus.reg_write_source, 32'd1);
      check({tag, "_level0"}, bus.cop_fifo_level, 32'd0);
      tick();
      check({tag, "_en_off"}, bus.reg_write_en, 32'd0);
   endtask

   initial begin
      bus.cop_write_en       = 1'b0;
      bus.cop_write_address  = '0;
      bus.cop_write_data     = '0;
      bus.host_write_en      = 1'b0;
      bus.host_write_address = '0;
      bus.host_write_data    = '0;

      // reset state
      tick();
      check("rst_en", bus.reg_write_en, 32'd0);
      check("rst_src", bus.reg_write_source, 32'd0);
      check("rst_addr", bus.reg_write_address, 32'd0);
      check("rst_data", bus.reg_write_data, 32'd0);
      check("rst_level", bus.cop_fifo_level, 32'd0);
      check("rst_cop_ready", bus.cop_write_ready, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // single copper write
      cop_single("cop1", 6'h05, 16'h1234);

      // host write with empty queue
      tick();
      bus.host_write_en      = 1'b1;
      bus.host_write_address = 6'h10;
      bus.host_write_data    = 16'hBEEF;
      #1;
      check("host_ready", bus.host_write_ready, 32'd1);
      tick();
      bus.host_write_en = 1'b0;
      #1;
      check("host_en", bus.reg_write_en, 32'd1);
      check("host_addr", bus.reg_write_address, 32'h10);
      check("host_data", bus.reg_write_data, 32'hBEEF);
      check("host_src", bus.reg_write_source, 32'd0);
      check("host_ready_off", bus.host_write_ready, 32'd0);
      tick();
      check("host_en_off", bus.reg_write_en, 32'd0);

      // six back-to-back copper writes, host idle
      q.delete();
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(cop_ent(i));
      traffic(6, 0, 0, -1);
      check("stream_ready_low", saw_ready_low, RDY_LOW_021);
      drain_and_compare("stream");

      // host held during copper traffic
      q.delete();
      exp_q.delete();
`ifdef VDP_COPPER_WRITE_FIFO_EN
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 8; i++) exp_q.push_back(cop_ent(8 * b + i));
         exp_q.push_back(host_ent(b));
      end
      for (int i = 24; i < 30; i++) exp_q.push_back(cop_ent(i));
`else
      for (int b = 0; b < 3; b++) begin
         exp_q.push_back(cop_ent(b));
         exp_q.push_back(host_ent(b));
      end
      for (int i = 3; i < 30; i++) exp_q.push_back(cop_ent(i));
`endif
      traffic(30, 3, 1, -1);
      check("starve_full_seen", saw_ready_low, 32'd1);
      drain_and_compare("starve");

      // reset in the middle of traffic
      repeat (3) tick();
      q.delete();
      traffic(30, 3, 1, 21);
      check("pre_rst_level", bus.cop_fifo_level, LVL_AT_RST);
      reset = 1'b1;
      #1;
      check("mid_rst_en", bus.reg_write_en, 32'd0);
      check("mid_rst_addr", bus.reg_write_address, 32'd0);
      check("mid_rst_data", bus.reg_write_data, 32'd0);
      check("mid_rst_src", bus.reg_write_source, 32'd0);
      check("mid_rst_level", bus.cop_fifo_level, 32'd0);
      check("mid_rst_cop_ready", bus.cop_write_ready, 32'd0);
      bus.host_write_en = 1'b1;
      #1;
      check("mid_rst_host_ready", bus.host_write_ready, 32'd0);
      bus.cop_write_en  = 1'b0;
      bus.host_write_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      q.delete();
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("post_rst_no_strobe", q.size(), 32'd0);
      check("post_rst_level", bus.cop_fifo_level, 32'd0);
      cop_single("cop2", 6'h3F, 16'h0F0F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
